// File: rtl/morz_tx.sv
// Morse code transmitter: accepts one digit/letter code per strobe and keys its
// dot/dash pattern onto M with standard unit timing (1/3 unit marks, 1 unit gaps, 3 unit tail).
module morz_tx #(
    parameter int UNIT = 2500000
) (
    input  logic       C,
    input  logic       nR,
    input  logic [4:0] D,
    input  logic       STB,
    output logic       RDY,
    output logic       M,
    output logic       ERR
);

    typedef enum logic [1:0] {IDLE, MARK, GAP, CGAP} stateT;

    localparam logic [23:0] UNIT_M1 = 24'(UNIT - 1);

    stateT       state, stateNext;
    logic [23:0] cycleCnt, cycleNext;
    logic [1:0]  unitsLeft, unitsNext;
    logic [4:0]  shiftReg, shiftNext;
    logic [2:0]  remaining, remNext;
    logic        errNext;
    logic        mReg, rdyReg, errReg;

    logic [4:0]  romBits;
    logic [2:0]  romLen;
    logic        romValid;
    logic        phaseDone;

    // Pattern ROM: elements left-aligned, MSB sent first, 1 = dash.
    always_comb begin
        romBits  = 5'b00000;
        romLen   = 3'd0;
        romValid = 1'b1;
        case (D)
            5'd0:    begin romBits = 5'b11111; romLen = 3'd5; end
            5'd1:    begin romBits = 5'b01111; romLen = 3'd5; end
            5'd2:    begin romBits = 5'b00111; romLen = 3'd5; end
            5'd3:    begin romBits = 5'b00011; romLen = 3'd5; end
            5'd4:    begin romBits = 5'b00001; romLen = 3'd5; end
            5'd5:    begin romBits = 5'b00000; romLen = 3'd5; end
            5'd6:    begin romBits = 5'b10000; romLen = 3'd5; end
            5'd7:    begin romBits = 5'b11000; romLen = 3'd5; end
            5'd8:    begin romBits = 5'b11100; romLen = 3'd5; end
            5'd9:    begin romBits = 5'b11110; romLen = 3'd5; end
            5'd16:   begin romBits = 5'b01000; romLen = 3'd2; end
            5'd17:   begin romBits = 5'b00000; romLen = 3'd1; end
            5'd18:   begin romBits = 5'b00100; romLen = 3'd4; end
            5'd19:   begin romBits = 5'b00000; romLen = 3'd4; end
            5'd20:   begin romBits = 5'b00000; romLen = 3'd2; end
            5'd21:   begin romBits = 5'b00000; romLen = 3'd3; end
            5'd22:   begin romBits = 5'b00100; romLen = 3'd3; end
            default: romValid = 1'b0;
        endcase
    end

    assign phaseDone = (cycleCnt == 24'd0) && (unitsLeft == 2'd0);

    // Each phase loads cycleCnt with UNIT-1 and unitsLeft with (units-1), so a
    // phase lasts exactly units*UNIT cycles and the next phase starts on the same edge.
    always_comb begin
        stateNext = state;
        cycleNext = cycleCnt;
        unitsNext = unitsLeft;
        shiftNext = shiftReg;
        remNext   = remaining;
        errNext   = 1'b0;

        if (state != IDLE) begin
            if (cycleCnt != 24'd0) begin
                cycleNext = cycleCnt - 24'd1;
            end else begin
                cycleNext = UNIT_M1;
                unitsNext = unitsLeft - 2'd1;
            end
        end

        case (state)
            IDLE: begin
                if (STB) begin
                    if (romValid) begin
                        stateNext = MARK;
                        shiftNext = romBits;
                        remNext   = romLen - 3'd1;
                        cycleNext = UNIT_M1;
                        unitsNext = romBits[4] ? 2'd2 : 2'd0;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            MARK: begin
                if (phaseDone) begin
                    cycleNext = UNIT_M1;
                    if (remaining != 3'd0) begin
                        stateNext = GAP;
                        unitsNext = 2'd0;
                    end else begin
                        stateNext = CGAP;
                        unitsNext = 2'd2;
                    end
                end
            end
            GAP: begin
                if (phaseDone) begin
                    stateNext = MARK;
                    shiftNext = {shiftReg[3:0], 1'b0};
                    remNext   = remaining - 3'd1;
                    cycleNext = UNIT_M1;
                    unitsNext = shiftReg[3] ? 2'd2 : 2'd0;
                end
            end
            CGAP: begin
                if (phaseDone) begin
                    stateNext = IDLE;
                    cycleNext = 24'd0;
                    unitsNext = 2'd0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from the next state so M and RDY never glitch.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state     <= IDLE;
            cycleCnt  <= 24'd0;
            unitsLeft <= 2'd0;
            shiftReg  <= 5'd0;
            remaining <= 3'd0;
            mReg      <= 1'b0;
            rdyReg    <= 1'b1;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            cycleCnt  <= cycleNext;
            unitsLeft <= unitsNext;
            shiftReg  <= shiftNext;
            remaining <= remNext;
            mReg      <= (stateNext == MARK);
            rdyReg    <= (stateNext == IDLE);
            errReg    <= errNext;
        end
    end

    assign M   = mReg;
    assign RDY = rdyReg;
    assign ERR = errReg;

endmodule

// File: tb/tb_morz_tx.sv
// Self-checking bench for morz_tx: directed and random characters compared against a
// waveform model built from the Morse pattern table.
module tb_morz_tx;

    localparam int UNIT = 4;

    logic       C;
    logic       nR;
    logic [4:0] D;
    logic       STB;
    logic       RDY;
    logic       M;
    logic       ERR;

    int assertCount = 0;
    int failCount   = 0;
    bit streamLog[$];

    morz_tx #(.UNIT(UNIT)) dut (
        .C   (C),
        .nR  (nR),
        .D   (D),
        .STB (STB),
        .RDY (RDY),
        .M   (M),
        .ERR (ERR)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    function automatic string patternOf(input int code);
        case (code)
            0:  return "-----";
            1:  return ".----";
            2:  return "..---";
            3:  return "...--";
            4:  return "....-";
            5:  return ".....";
            6:  return "-....";
            7:  return "--...";
            8:  return "---..";
            9:  return "----.";
            16: return ".-";
            17: return ".";
            18: return "..-.";
            19: return "....";
            20: return "..";
            21: return "...";
            22: return "..-";
            default: return "";
        endcase
    endfunction

    // Expected M, one entry per cycle following the accepting edge.
    task automatic buildWave(input string p, output bit w[$]);
        w = {};
        for (int e = 0; e < p.len(); e++) begin
            if (e > 0) repeat (UNIT) w.push_back(1'b0);
            repeat ((p[e] == "-") ? 3 * UNIT : UNIT) w.push_back(1'b1);
        end
        repeat (3 * UNIT) w.push_back(1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkText(input string tag, input string obs, input string exp);
        assertCount++;
        assert (obs == exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    // Presents a code with STB for one edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input int code);
        @(negedge C);
        D   = 5'(code);
        STB = 1'b1;
        @(posedge C);
        #1;
        STB = 1'b0;
    endtask

    // Called just after the accepting edge; follows the whole character.
    task automatic runWave(input int code, input bit noisy);
        bit w[$];
        buildWave(patternOf(code), w);
        D = 5'($urandom);
        for (int j = 0; j < w.size(); j++) begin
            if (noisy) begin
                STB = 1'($urandom_range(0, 1));
                D   = 5'($urandom);
            end
            @(negedge C);
            checkOutput($sformatf("M[%0d] code %0d", j, code), M, w[j]);
            checkOutput($sformatf("RDY busy[%0d]", j), RDY, 1'b0);
            checkOutput($sformatf("ERR busy[%0d]", j), ERR, 1'b0);
            @(posedge C);
            #1;
        end
        STB = 1'b0;
        @(negedge C);
        checkOutput($sformatf("RDY done code %0d", code), RDY, 1'b1);
        checkOutput("M done", M, 1'b0);
    endtask

    task automatic rejectCase(input int code);
        applyStimulus(code);
        @(negedge C);
        checkOutput($sformatf("ERR pulse code %0d", code), ERR, 1'b1);
        checkOutput("RDY on reject", RDY, 1'b1);
        checkOutput("M on reject", M, 1'b0);
        @(posedge C);
        #1;
        @(negedge C);
        checkOutput("ERR one cycle", ERR, 1'b0);
        checkOutput("RDY after reject", RDY, 1'b1);
    endtask

    // Streaming with STB held high; the following edge is the next accept.
    task automatic streamChar(input int code, input int nextCode, input bit last);
        bit w[$];
        if (last) STB = 1'b0;
        else      D   = 5'(nextCode);
        buildWave(patternOf(code), w);
        for (int j = 0; j < w.size(); j++) begin
            @(negedge C);
            checkOutput($sformatf("stream M[%0d] code %0d", j, code), M, w[j]);
            streamLog.push_back(M);
            @(posedge C);
            #1;
        end
        @(negedge C);
        checkOutput("stream RDY", RDY, 1'b1);
        checkOutput("stream M idle", M, 1'b0);
        streamLog.push_back(M);
        @(posedge C);
        #1;
    endtask

    initial begin
        string got[$];
        int    zeroRuns[$];
        string cur;
        int    idx;
        int    runLen;
        bit    runVal;
        int    code;
        string expStream[4];

        nR  = 1'b1;
        D   = 5'd0;
        STB = 1'b0;

        #2 nR = 1'b0;
        #1;
        checkOutput("reset M", M, 1'b0);
        checkOutput("reset RDY", RDY, 1'b1);
        checkOutput("reset ERR", ERR, 1'b0);
        @(posedge C);
        #1 nR = 1'b1;

        // E, A, 0 directed
        applyStimulus(17);
        runWave(17, 1'b0);
        applyStimulus(16);
        runWave(16, 1'b0);
        applyStimulus(0);
        runWave(0, 1'b0);

        rejectCase(10);
        rejectCase(31);

        applyStimulus(21);
        runWave(21, 1'b1);

        // Reset in the middle of the first dash of 7
        applyStimulus(7);
        repeat (5) @(posedge C);
        #3;
        checkOutput("mid dash M", M, 1'b1);
        nR = 1'b0;
        #1;
        checkOutput("async reset M", M, 1'b0);
        checkOutput("async reset RDY", RDY, 1'b1);
        checkOutput("async reset ERR", ERR, 1'b0);
        @(posedge C);
        #1;
        checkOutput("held reset M", M, 1'b0);
        nR = 1'b1;
        applyStimulus(5);
        runWave(5, 1'b0);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 3) == 0)
                code = $urandom_range(0, 1) ? $urandom_range(10, 15) : $urandom_range(23, 31);
            else if ($urandom_range(0, 1) == 0)
                code = $urandom_range(0, 9);
            else
                code = $urandom_range(16, 22);
            if (patternOf(code) == "") rejectCase(code);
            else begin
                applyStimulus(code);
                runWave(code, 1'b1);
            end
        end

        // Continuous I/U stream
        @(negedge C);
        D   = 5'd20;
        STB = 1'b1;
        @(posedge C);
        #1;
        streamChar(20, 22, 1'b0);
        streamChar(22, 20, 1'b0);
        streamChar(20, 22, 1'b0);
        streamChar(22, 0, 1'b1);

        // Decode the logged stream from mark/space run lengths
        cur = "";
        idx = 0;
        while (idx < streamLog.size()) begin
            runVal = streamLog[idx];
            runLen = 0;
            while (idx < streamLog.size() && streamLog[idx] == runVal) begin
                runLen++;
                idx++;
            end
            if (runVal) begin
                if (runLen == UNIT)          cur = {cur, "."};
                else if (runLen == 3 * UNIT) cur = {cur, "-"};
                else                         cur = {cur, "?"};
            end else if (runLen > UNIT) begin
                got.push_back(cur);
                zeroRuns.push_back(runLen);
                cur = "";
            end
        end
        expStream = '{"..", "..-", "..", "..-"};
        checkOutput("stream char count", got.size(), 4);
        for (int c = 0; c < got.size() && c < 4; c++) begin
            checkText($sformatf("stream char %0d", c), got[c], expStream[c]);
            checkOutput($sformatf("stream low time %0d", c), zeroRuns[c], 3 * UNIT + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
